// File: rtl/controller_data_stack_pkg.sv
// ---------------------------------------------------------------------------
// controller_data_stack_pkg : sizing shared by the controller and operand stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package controller_data_stack_pkg;

   localparam int CD_N      = 16;
   localparam int CDS_DEPTH = 16;
   localparam int CDS_PTR_N = 4;

   // Encoded as {push, pop}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } cds_op_e;

endpackage

`default_nettype wire

// File: rtl/controller_data_stack_if.sv
// ---------------------------------------------------------------------------
// controller_data_stack_if : controller <-> operand stack signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface controller_data_stack_if
   import controller_data_stack_pkg::*;
#(
   parameter int WIDTH = CD_N,
   parameter int PTR_W = CDS_PTR_N
) ();

   logic             dt_clear;
   logic             dt_push;
   logic             dt_pop;
   logic [WIDTH-1:0] dt_din;
   logic [WIDTH-1:0] dt_data;
   logic             dt_empty;
   logic             dt_full;
   logic [PTR_W:0]   dt_count;
   logic             dt_overflow;
   logic             dt_underflow;

   modport master (
      output dt_clear, dt_push, dt_pop, dt_din,
      input  dt_data, dt_empty, dt_full, dt_count, dt_overflow, dt_underflow
   );

   modport slave (
      input  dt_clear, dt_push, dt_pop, dt_din,
      output dt_data, dt_empty, dt_full, dt_count, dt_overflow, dt_underflow
   );

endinterface

`default_nettype wire

// File: rtl/controller_data_stack_mem.sv
// ---------------------------------------------------------------------------
// controller_stack_mem : DEPTH x WIDTH array, sync write, async read, no reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module controller_stack_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  wire logic             clk,
   input  wire logic             i_we,
   input  wire logic [AW-1:0]    i_waddr,
   input  wire logic [WIDTH-1:0] i_wdata,
   input  wire logic [AW-1:0]    i_raddr,
   output logic      [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/controller_data_stack.sv
// ---------------------------------------------------------------------------
// controller_data_stack : LIFO operand stack with registered show-ahead top
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module controller_data_stack
   import controller_data_stack_pkg::*;
#(
   parameter int WIDTH = CD_N,
   parameter int DEPTH = CDS_DEPTH,
   parameter int PTR_W = CDS_PTR_N
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   controller_data_stack_if.slave      s
);

   localparam logic [PTR_W:0]   c_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   c_DEPTH = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] c_A_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] c_A_TWO = PTR_W'(2);

   logic [PTR_W:0]   r_count;
   logic [WIDTH-1:0] r_top;
   logic             r_ovf;
   logic             r_unf;

   logic [PTR_W:0]   w_cnt_nxt;
   logic [WIDTH-1:0] w_top_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;
   logic             w_we;
   logic [PTR_W-1:0] w_waddr;
   logic [PTR_W-1:0] w_raddr;
   logic [WIDTH-1:0] w_rdata;
   logic             w_empty;
   logic             w_full;
   cds_op_e          w_op;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_DEPTH);
   assign w_op    = cds_op_e'({s.dt_push, s.dt_pop});
   // Entry just below the current top; only consulted when count >= 2.
   assign w_raddr = r_count[PTR_W-1:0] - c_A_TWO;

   always_comb begin
      w_cnt_nxt = r_count;
      w_top_nxt = r_top;
      w_ovf_nxt = r_ovf;
      w_unf_nxt = r_unf;
      w_we      = 1'b0;
      w_waddr   = r_count[PTR_W-1:0];
      if (s.dt_clear) begin
         w_cnt_nxt = '0;
         w_top_nxt = '0;
         w_ovf_nxt = 1'b0;
         w_unf_nxt = 1'b0;
      end else begin
         unique case (w_op)
            OP_REPL: begin
               w_we      = 1'b1;
               w_top_nxt = s.dt_din;
               if (w_empty) begin
                  w_cnt_nxt = c_ONE;
               end else begin
                  w_waddr = r_count[PTR_W-1:0] - c_A_ONE;
               end
            end
            OP_PUSH: begin
               if (w_full) begin
                  w_ovf_nxt = 1'b1;
               end else begin
                  w_we      = 1'b1;
                  w_cnt_nxt = r_count + c_ONE;
                  w_top_nxt = s.dt_din;
               end
            end
            OP_POP: begin
               if (w_empty) begin
                  w_unf_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_count - c_ONE;
                  w_top_nxt = (r_count == c_ONE) ? '0 : w_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_top   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_cnt_nxt;
         r_top   <= w_top_nxt;
         r_ovf   <= w_ovf_nxt;
         r_unf   <= w_unf_nxt;
      end
   end

   controller_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (s.dt_din),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   assign s.dt_data      = r_top;
   assign s.dt_count     = r_count;
   assign s.dt_empty     = w_empty;
   assign s.dt_full      = w_full;
   assign s.dt_overflow  = r_ovf;
   assign s.dt_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_controller_data_stack.sv
// ---------------------------------------------------------------------------
// tb_controller_data_stack : directed self-checking bench for the operand stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_controller_data_stack;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   controller_data_stack_if #(.WIDTH(16), .PTR_W(4)) dif ();

   controller_data_stack #(
      .WIDTH (16),
      .DEPTH (16),
      .PTR_W (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .s   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input int data,
                            input logic emp, input logic ful,
                            input logic ovf, input logic unf);
      chk({tag, ".count"}, 32'(dif.dt_count), 32'(cnt));
      chk({tag, ".data"},  32'(dif.dt_data),  32'(data));
      chk({tag, ".empty"}, 32'(dif.dt_empty), 32'(emp));
      chk({tag, ".full"},  32'(dif.dt_full),  32'(ful));
      chk({tag, ".ovf"},   32'(dif.dt_overflow),  32'(ovf));
      chk({tag, ".unf"},   32'(dif.dt_underflow), 32'(unf));
   endtask

   // Drive one cycle of control, then sample 1 time unit after the edge.
   task automatic cyc(input logic clr, input logic psh, input logic pp, input int din);
      dif.dt_clear = clr;
      dif.dt_push  = psh;
      dif.dt_pop   = pp;
      dif.dt_din   = 16'(din);
      @(posedge clk);
      #1;
      dif.dt_clear = 1'b0;
      dif.dt_push  = 1'b0;
      dif.dt_pop   = 1'b0;
      dif.dt_din   = '0;
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      dif.dt_clear = 1'b0;
      dif.dt_push  = 1'b0;
      dif.dt_pop   = 1'b0;
      dif.dt_din   = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(0, 0, 0, 0);
      chk_state("reset", 0, 0, 1, 0, 0, 0);

      cyc(0, 1, 0, 5);  chk_state("push5", 1, 5, 0, 0, 0, 0);
      cyc(0, 1, 0, 7);  chk_state("push7", 2, 7, 0, 0, 0, 0);
      cyc(0, 1, 0, 9);  chk_state("push9", 3, 9, 0, 0, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop1",  2, 7, 0, 0, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop2",  1, 5, 0, 0, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop3",  0, 0, 1, 0, 0, 0);

      for (int i = 1; i <= 16; i++) begin
         cyc(0, 1, 0, i);
         chk("fill.data", 32'(dif.dt_data), 32'(i));
      end
      chk_state("full16", 16, 16, 0, 1, 0, 0);
      cyc(0, 1, 0, 99); chk_state("push_ovf", 16, 16, 0, 1, 1, 0);
      cyc(0, 0, 1, 0);  chk_state("pop_after_ovf", 15, 15, 0, 0, 1, 0);
      cyc(0, 0, 1, 0);  chk_state("pop_deep", 14, 14, 0, 0, 1, 0);

      cyc(1, 0, 0, 0);  chk_state("clear1", 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop_empty", 0, 0, 1, 0, 0, 1);
      cyc(0, 1, 1, 42); chk_state("repl_empty", 1, 42, 0, 0, 0, 1);
      cyc(0, 0, 1, 0);  chk_state("pop_42", 0, 0, 1, 0, 0, 1);

      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 3);
      cyc(0, 1, 0, 4);  chk_state("hold34", 2, 4, 0, 0, 0, 0);
      cyc(0, 1, 1, 8);  chk_state("repl8", 2, 8, 0, 0, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop_to3", 1, 3, 0, 0, 0, 0);

      cyc(1, 0, 0, 0);
      for (int i = 1; i <= 16; i++) cyc(0, 1, 0, i);
      cyc(0, 1, 1, 77); chk_state("repl_full", 16, 77, 0, 1, 0, 0);
      cyc(0, 0, 1, 0);  chk_state("pop_repl_full", 15, 15, 0, 0, 0, 0);

      // Flush with a sticky flag set and a clear that overrides a push
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 20 + i);
      chk_state("six", 6, 25, 0, 0, 0, 1);
      cyc(1, 1, 0, 55); chk_state("clear6", 0, 0, 1, 0, 0, 0);

      // Asynchronous reset arriving mid-cycle while a push is being driven
      cyc(0, 1, 0, 1);
      cyc(0, 1, 0, 2);
      chk_state("pre_rst", 2, 2, 0, 0, 0, 0);
      dif.dt_push = 1'b1;
      dif.dt_din  = 16'd5;
      #2;
      rst = 1'b1;
      #1;
      chk_state("async_rst", 0, 0, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_state("rst_held", 0, 0, 1, 0, 0, 0);
      rst         = 1'b0;
      dif.dt_push = 1'b0;
      dif.dt_din  = '0;
      cyc(0, 0, 0, 0);  chk_state("post_rst", 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 11); chk_state("post_rst_push", 1, 11, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
